hd44780_bus_sequencer: RTL

Low-level bus engine for the HD44780 character LCD in 4-bit write-only mode. Performs the power-on nibble initialisation, then accepts byte writes (command or data) over a valid/ready handshake. Each byte is split into two nibbles and strobed onto the LCD pins with the setup, pulse-width, hold and execution delays the controller requires. Sits between the display-content controller (which decides what to write) and the LCD pins.

---
 rtl/hd44780_bus_sequencer_if.sv | 22 ++
 rtl/hd44780_bus_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hd44780_bus_sequencer_if.sv
// Byte-write handshake between the display controller and the HD44780 bus sequencer.
// Signals: i_valid/i_rs/i_data from the requester, o_ready from the sequencer.
interface hd44780_bus_sequencer_if;
  logic       i_valid;
  logic       i_rs;
  logic [7:0] i_data;
  logic       o_ready;

  modport master (
    output i_valid,
    output i_rs,
    output i_data,
    input  o_ready
  );

  modport slave (
    input  i_valid,
    input  i_rs,
    input  i_data,
    output o_ready
  );
endinterface

// File: rtl/hd44780_bus_sequencer.sv
// HD44780 4-bit write-only bus engine: power-on nibble init, then byte writes
// split into two timed E strobes followed by an execution wait.
// Ports: i_clk, i_reset (async, active high), bus (slave handshake),
//   o_init_done, o_lcd_rs, o_lcd_rw (tied 0), o_lcd_e, o_lcd_d (D7..D4).
module hd44780_bus_sequencer #(
  parameter int CW      = 22,
  parameter int T_PWRON = 4_000_000,
  parameter int T_INIT1 = 410_000,
  parameter int T_INIT2 = 10_000,
  parameter int T_AS    = 5,
  parameter int T_PW    = 25,
  parameter int T_H     = 2,
  parameter int T_NIB   = 100,
  parameter int T_EXEC  = 3_700,
  parameter int T_LONG  = 152_000
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  hd44780_bus_sequencer_if.slave  bus,
  output logic                    o_init_done,
  output logic                    o_lcd_rs,
  output logic                    o_lcd_rw,
  output logic                    o_lcd_e,
  output logic [3:0]              o_lcd_d
);

  typedef enum logic [2:0] {
    S_PWR, S_SETUP, S_EHIGH, S_HOLD, S_GAP, S_WAIT, S_IDLE
  } state_t;

  // Counters load N-1 so each timed state lasts exactly N cycles.
  localparam logic [CW-1:0] L_PWRON = CW'(T_PWRON - 1);
  localparam logic [CW-1:0] L_INIT1 = CW'(T_INIT1 - 1);
  localparam logic [CW-1:0] L_INIT2 = CW'(T_INIT2 - 1);
  localparam logic [CW-1:0] L_AS    = CW'(T_AS - 1);
  localparam logic [CW-1:0] L_PW    = CW'(T_PW - 1);
  localparam logic [CW-1:0] L_H     = CW'(T_H - 1);
  localparam logic [CW-1:0] L_NIB   = CW'(T_NIB - 1);
  localparam logic [CW-1:0] L_EXEC  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] L_LONG  = CW'(T_LONG - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_step;
  logic            r_lo;
  logic            r_long;
  logic [3:0]      r_lo_nib;
  logic            r_ready;
  logic            r_init_done;
  logic            r_e;
  logic            r_rs;
  logic [3:0]      r_d;

  logic            w_done;
  logic            w_acc;
  logic            w_long;

  assign w_done = (r_cnt == '0);
  assign w_acc  = bus.i_valid && r_ready;
  // Clear display and return home need the long execution wait.
  assign w_long = !bus.i_rs && (bus.i_data[7:2] == 6'd0)
                  && (bus.i_data != 8'd0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_PWR;
      r_cnt       <= L_PWRON;
      r_step      <= 2'd0;
      r_lo        <= 1'b0;
      r_long      <= 1'b0;
      r_lo_nib    <= 4'd0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_e         <= 1'b0;
      r_rs        <= 1'b0;
      r_d         <= 4'd0;
    end else if (r_state != S_IDLE && !w_done) begin
      r_cnt <= r_cnt - 1'b1;
    end else begin
      unique case (r_state)
        S_PWR: begin
          r_state <= S_SETUP;
          r_cnt   <= L_AS;
          r_step  <= 2'd0;
          r_rs    <= 1'b0;
          r_d     <= 4'h3;
        end
        S_SETUP: begin
          r_state <= S_EHIGH;
          r_cnt   <= L_PW;
          r_e     <= 1'b1;
        end
        S_EHIGH: begin
          r_state <= S_HOLD;
          r_cnt   <= L_H;
          r_e     <= 1'b0;
        end
        S_HOLD: begin
          if (!r_init_done) begin
            r_state <= S_WAIT;
            unique case (r_step)
              2'd0:    r_cnt <= L_INIT1;
              2'd1:    r_cnt <= L_INIT2;
              default: r_cnt <= L_EXEC;
            endcase
          end else if (!r_lo) begin
            r_state <= S_GAP;
            r_cnt   <= L_NIB;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= r_long ? L_LONG : L_EXEC;
          end
        end
        S_GAP: begin
          r_state <= S_SETUP;
          r_cnt   <= L_AS;
          r_lo    <= 1'b1;
          r_d     <= r_lo_nib;
        end
        S_WAIT: begin
          if (!r_init_done && r_step != 2'd3) begin
            r_state <= S_SETUP;
            r_cnt   <= L_AS;
            r_step  <= r_step + 1'b1;
            // Fourth init nibble switches the controller to 4-bit mode.
            r_d     <= (r_step == 2'd2) ? 4'h2 : 4'h3;
          end else begin
            r_state     <= S_IDLE;
            r_init_done <= 1'b1;
            r_ready     <= 1'b1;
          end
        end
        S_IDLE: begin
          if (w_acc) begin
            r_state  <= S_SETUP;
            r_cnt    <= L_AS;
            r_ready  <= 1'b0;
            r_lo     <= 1'b0;
            r_long   <= w_long;
            r_rs     <= bus.i_rs;
            r_d      <= bus.i_data[7:4];
            r_lo_nib <= bus.i_data[3:0];
          end
        end
        default: begin
          r_state <= S_PWR;
          r_cnt   <= L_PWRON;
        end
      endcase
    end
  end

  assign bus.o_ready  = r_ready;
  assign o_init_done  = r_init_done;
  assign o_lcd_rs     = r_rs;
  assign o_lcd_rw     = 1'b0;
  assign o_lcd_e      = r_e;
  assign o_lcd_d      = r_d;

endmodule
